// File: rtl/jv1_sector_bridge_if.sv
// +----------------------------------------------------------------------------+
// | Module   : jv1_sector_bridge_if                                            |
// | Brief    : FDC sector port, SD block port and mount signals of the bridge. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface jv1_sector_bridge_if;
  logic        req_rd;
  logic        req_wr;
  logic [6:0]  track;
  logic [3:0]  sector;
  logic [7:0]  buf_addr;
  logic [7:0]  buf_dout;
  logic [7:0]  buf_din;
  logic        buf_we;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;

  // Bridge side.
  modport slave (
    input  req_rd, req_wr, track, sector, buf_addr, buf_din, buf_we,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  img_mounted, img_readonly, img_size,
    output buf_dout, busy, done, err, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  // FDC / hps_io side.
  modport master (
    output req_rd, req_wr, track, sector, buf_addr, buf_din, buf_we,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output img_mounted, img_readonly, img_size,
    input  buf_dout, busy, done, err, sd_lba, sd_rd, sd_wr, sd_buff_din
  );
endinterface

`default_nettype wire

// File: rtl/jv1_sector_bridge.sv
// +----------------------------------------------------------------------------+
// | Module   : jv1_sector_bridge                                               |
// | Brief    : JV1 track/sector to 512-byte SD block bridge with RMW writes.   |
// |            JV1_SECTOR_CACHE_EN enables the single-block hit cache.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module jv1_sector_bridge #(
  parameter int TRACKS = 40,
  parameter int SPT    = 10
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  jv1_sector_bridge_if.slave   bus
);

  localparam logic [31:0] c_SPT    = 32'(SPT);
  localparam logic [31:0] c_TRACKS = 32'(TRACKS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_XFER = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_XFER = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [6:0]  r_track;
  logic [3:0]  r_sector;
  logic        r_is_wr;
  logic [63:0] r_size;
  logic        r_ro;
  logic        r_abort;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_sd_rd;
  logic        r_sd_wr;
  logic [31:0] r_sd_lba;
  logic [7:0]  r_buf_dout;
  logic [7:0]  r_sd_buff_din;
  logic [7:0]  r_block [0:511];
  logic [7:0]  r_stage [0:255];

  logic [9:0]  w_idx;
  logic [8:0]  w_lba;
  logic        w_half;
  logic [63:0] w_end;
  logic        w_ok;
  logic        w_hit;
  logic        w_blk_we;
  logic [7:0]  w_blk_wdata;

  assign w_idx  = 10'(r_track) * 10'(SPT) + 10'(r_sector);
  assign w_lba  = w_idx[9:1];
  assign w_half = w_idx[0];
  assign w_end  = {45'd0, ({1'b0, w_idx} + 11'd1), 8'd0};

  // A mount during the operation forces the error path as well.
  assign w_ok = ({28'd0, r_sector} < c_SPT) && ({25'd0, r_track} < c_TRACKS) &&
                (r_size != 64'd0) && (w_end <= r_size) && !(r_is_wr && r_ro) && !r_abort;

`ifdef JV1_SECTOR_CACHE_EN
  logic       r_cache_valid;
  logic [8:0] r_cached_lba;

  assign w_hit = r_cache_valid && (r_cached_lba == w_lba);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cache_valid <= 1'b0;
      r_cached_lba  <= 9'd0;
    end else if (bus.img_mounted) begin
      r_cache_valid <= 1'b0;
    end else if (r_state == S_RD_XFER && !bus.sd_ack && !r_abort) begin
      r_cache_valid <= 1'b1;
      r_cached_lba  <= w_lba;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.req_rd || bus.req_wr) w_next = S_CHECK;
      S_CHECK: begin
        if (!w_ok)      w_next = S_DONE;
        else if (w_hit) w_next = r_is_wr ? S_WR_REQ : S_DONE;
        else            w_next = S_RD_REQ;
      end
      S_RD_REQ:  if (bus.sd_ack) w_next = S_RD_XFER;
      S_RD_XFER: if (!bus.sd_ack)
                   w_next = (r_is_wr && !r_abort && !bus.img_mounted) ? S_WR_REQ : S_DONE;
      S_WR_REQ:  if (bus.sd_ack) w_next = S_WR_XFER;
      S_WR_XFER: if (!bus.sd_ack) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_track       <= 7'd0;
      r_sector      <= 4'd0;
      r_is_wr       <= 1'b0;
      r_size        <= 64'd0;
      r_ro          <= 1'b0;
      r_abort       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_sd_rd       <= 1'b0;
      r_sd_wr       <= 1'b0;
      r_sd_lba      <= 32'd0;
      r_buf_dout    <= 8'd0;
      r_sd_buff_din <= 8'd0;
    end else begin
      r_busy  <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done  <= (w_next == S_DONE);
      r_sd_rd <= (w_next == S_RD_REQ);
      r_sd_wr <= (w_next == S_WR_REQ);

      if (r_state == S_IDLE && (bus.req_rd || bus.req_wr)) begin
        r_track  <= bus.track;
        r_sector <= bus.sector;
        r_is_wr  <= !bus.req_rd;
        r_err    <= 1'b0;
        r_abort  <= 1'b0;
      end else if (bus.img_mounted && r_state != S_IDLE && r_state != S_DONE) begin
        r_abort <= 1'b1;
      end

      if (w_next == S_DONE)
        r_err <= (r_state == S_CHECK && !w_ok) || r_abort || bus.img_mounted;

      if (r_state == S_CHECK) r_sd_lba <= {23'd0, w_lba};

      if (bus.img_mounted) begin
        r_size <= bus.img_size;
        r_ro   <= bus.img_readonly;
      end

      r_buf_dout    <= r_block[{w_half, bus.buf_addr}];
      // Outgoing block: staged sector in the target half, cached data elsewhere.
      r_sd_buff_din <= (bus.sd_buff_addr[8] == w_half) ? r_stage[bus.sd_buff_addr[7:0]]
                                                      : r_block[bus.sd_buff_addr];
    end
  end

  // Target-half bytes are mirrored into the block so it stays coherent after a write.
  assign w_blk_we    = (r_state == S_RD_XFER && bus.sd_buff_wr) ||
                       (r_state == S_WR_XFER && bus.sd_buff_addr[8] == w_half);
  assign w_blk_wdata = (r_state == S_RD_XFER) ? bus.sd_buff_dout
                                              : r_stage[bus.sd_buff_addr[7:0]];

  always_ff @(posedge clk_sys) begin
    if (w_blk_we)   r_block[bus.sd_buff_addr] <= w_blk_wdata;
    if (bus.buf_we) r_stage[bus.buf_addr]     <= bus.buf_din;
  end

  assign bus.buf_dout    = r_buf_dout;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.sd_lba      = r_sd_lba;
  assign bus.sd_rd       = r_sd_rd;
  assign bus.sd_wr       = r_sd_wr;
  assign bus.sd_buff_din = r_sd_buff_din;

endmodule

`default_nettype wire

// File: tb/tb_jv1_sector_bridge.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_jv1_sector_bridge                                            |
// | Brief    : Directed bench for jv1_sector_bridge with a small SD disk model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_jv1_sector_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jv1_sector_bridge_if bus ();

  jv1_sector_bridge #(.TRACKS(40), .SPT(10)) dut (
    .clk_sys (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] disk [0:15][0:511];
  bit         g_mount_mid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] init_byte(input int l, input int a);
    logic [8:0] aa;
    aa = 9'(a);
    if (l == 0) return aa[7:0];
    return aa[7:0] ^ 8'(l * 17) ^ (aa[8] ? 8'h5A : 8'h00);
  endfunction

  task automatic mount(input logic [63:0] size, input bit ro);
    bus.img_size     = size;
    bus.img_readonly = ro;
    bus.img_mounted  = 1'b1;
    tick;
    bus.img_mounted  = 1'b0;
    tick;
  endtask

  task automatic serve_read(input logic [31:0] exp_lba);
    int l;
    l = int'(bus.sd_lba[3:0]);
    chk("rd_lba", 64'(bus.sd_lba), 64'(exp_lba));
    tick;
    tick;
    chk("rd_held", 64'(bus.sd_rd), 64'd1);
    bus.sd_ack = 1'b1;
    tick;
    chk("rd_drop", 64'(bus.sd_rd), 64'd0);
    for (int i = 0; i < 512; i++) begin
      bus.sd_buff_addr = 9'(i);
      bus.sd_buff_dout = disk[l][i];
      bus.sd_buff_wr   = 1'b1;
      bus.img_mounted  = g_mount_mid && (i == 100);
      tick;
    end
    bus.sd_buff_wr  = 1'b0;
    bus.img_mounted = 1'b0;
    bus.sd_ack      = 1'b0;
  endtask

  task automatic serve_write(input logic [31:0] exp_lba);
    int l;
    l = int'(bus.sd_lba[3:0]);
    chk("wr_lba", 64'(bus.sd_lba), 64'(exp_lba));
    tick;
    chk("wr_held", 64'(bus.sd_wr), 64'd1);
    bus.sd_ack = 1'b1;
    tick;
    chk("wr_drop", 64'(bus.sd_wr), 64'd0);
    for (int i = 0; i < 512; i++) begin
      bus.sd_buff_addr = 9'(i);
      tick;
      disk[l][i] = bus.sd_buff_din;
    end
    bus.sd_ack = 1'b0;
  endtask

  task automatic run_op(input bit wr, input bit both, input logic [6:0] t, input logic [3:0] s,
                        input logic [31:0] exp_lba, output logic o_err,
                        output int n_rd, output int n_wr, output int cyc);
    bit got_done;
    n_rd = 0; n_wr = 0; cyc = 0; o_err = 1'b1; got_done = 1'b0;
    bus.track  = t;
    bus.sector = s;
    bus.req_rd = !wr || both;
    bus.req_wr = wr || both;
    tick;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    cyc = 1;
    chk("busy_rise", 64'(bus.busy), 64'd1);
    while (!got_done && cyc < 4000) begin
      tick;
      cyc++;
      if (bus.done) begin
        got_done = 1'b1;
        o_err    = bus.err;
      end else if (bus.sd_rd) begin
        serve_read(exp_lba);
        n_rd++;
      end else if (bus.sd_wr) begin
        serve_write(exp_lba);
        n_wr++;
      end
    end
    if (!got_done) chk("done_timeout", 64'd1, 64'd0);
    tick;
    chk("done_single", 64'(bus.done), 64'd0);
    chk("busy_fall", 64'(bus.busy), 64'd0);
    chk("err_held", 64'(bus.err), 64'(o_err));
  endtask

  task automatic chk_sector(input string tag, input int l, input bit h);
    for (int i = 0; i < 256; i++) begin
      bus.buf_addr = 8'(i);
      tick;
      chk(tag, 64'(bus.buf_dout), 64'(disk[l][{h, 8'(i)}]));
    end
  endtask

  logic e;
  int   nr, nw, cy;

  initial begin
    for (int l = 0; l < 16; l++)
      for (int a = 0; a < 512; a++)
        disk[l][a] = init_byte(l, a);

    rst_n = 1'b0;
    bus.req_rd = 0; bus.req_wr = 0; bus.track = 0; bus.sector = 0;
    bus.buf_addr = 0; bus.buf_din = 0; bus.buf_we = 0;
    bus.sd_ack = 0; bus.sd_buff_addr = 0; bus.sd_buff_dout = 0; bus.sd_buff_wr = 0;
    bus.img_mounted = 0; bus.img_readonly = 0; bus.img_size = 0;
    tick; tick;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_sd_rd", 64'(bus.sd_rd), 64'd0);
    chk("rst_sd_wr", 64'(bus.sd_wr), 64'd0);
    chk("rst_sd_lba", 64'(bus.sd_lba), 64'd0);
    rst_n = 1'b1;
    tick;

    // First read: block 0 loaded, lower half returned.
    mount(64'd102400, 1'b0);
    run_op(1'b0, 1'b0, 7'd0, 4'd0, 32'd0, e, nr, nw, cy);
    chk("rd0_err", 64'(e), 64'd0);
    chk("rd0_nrd", 64'(nr), 64'd1);
    chk_sector("rd0_data", 0, 1'b0);

    // Same block, upper half.
    run_op(1'b0, 1'b0, 7'd0, 4'd1, 32'd0, e, nr, nw, cy);
    chk("rd1_err", 64'(e), 64'd0);
`ifdef JV1_SECTOR_CACHE_EN
    chk("rd1_hit_nrd", 64'(nr), 64'd0);
    chk("rd1_hit_fast", 64'(cy <= 3), 64'd1);
`else
    chk("rd1_nrd", 64'(nr), 64'd1);
`endif
    bus.buf_addr = 8'd5;
    tick;
    chk("rd1_byte5", 64'(bus.buf_dout), 64'd5);

    // Out-of-range sector and track.
    run_op(1'b0, 1'b0, 7'd0, 4'd10, 32'd0, e, nr, nw, cy);
    chk("sec10_err", 64'(e), 64'd1);
    chk("sec10_nrd", 64'(nr), 64'd0);
    chk("sec10_fast", 64'(cy <= 3), 64'd1);
    run_op(1'b0, 1'b0, 7'd40, 4'd0, 32'd0, e, nr, nw, cy);
    chk("trk40_err", 64'(e), 64'd1);
    chk("trk40_nrd", 64'(nr), 64'd0);
    chk("trk40_fast", 64'(cy <= 3), 64'd1);

    // Image size boundary: idx 13 needs 3584 bytes.
    mount(64'd3328, 1'b0);
    run_op(1'b0, 1'b0, 7'd1, 4'd3, 32'd6, e, nr, nw, cy);
    chk("size_short_err", 64'(e), 64'd1);
    chk("size_short_nrd", 64'(nr), 64'd0);
    chk("size_short_lba", 64'(bus.sd_lba), 64'd6);
    mount(64'd3584, 1'b0);
    run_op(1'b0, 1'b0, 7'd1, 4'd3, 32'd6, e, nr, nw, cy);
    chk("size_exact_err", 64'(e), 64'd0);
    chk("size_exact_nrd", 64'(nr), 64'd1);
    chk_sector("size_exact_data", 6, 1'b1);

    // Write miss: pre-read lba 1 then write lba 1 with the lower half replaced.
    mount(64'd102400, 1'b0);
    for (int i = 0; i < 256; i++) begin
      bus.buf_addr = 8'(i);
      bus.buf_din  = 8'hA5;
      bus.buf_we   = 1'b1;
      tick;
    end
    bus.buf_we = 1'b0;
    run_op(1'b1, 1'b0, 7'd0, 4'd2, 32'd1, e, nr, nw, cy);
    chk("wr_err", 64'(e), 64'd0);
    chk("wr_nrd", 64'(nr), 64'd1);
    chk("wr_nwr", 64'(nw), 64'd1);
    for (int i = 0; i < 512; i++)
      chk("wr_block", 64'(disk[1][i]), 64'((i < 256) ? 8'hA5 : init_byte(1, i)));
    run_op(1'b0, 1'b0, 7'd0, 4'd2, 32'd1, e, nr, nw, cy);
    chk("rd_after_wr_err", 64'(e), 64'd0);
    chk_sector("rd_after_wr_lo", 1, 1'b0);
    run_op(1'b0, 1'b0, 7'd0, 4'd3, 32'd1, e, nr, nw, cy);
    chk_sector("rd_after_wr_hi", 1, 1'b1);

    // Read-only image: write refused, simultaneous read/write treated as read.
    mount(64'd102400, 1'b1);
    run_op(1'b1, 1'b0, 7'd0, 4'd2, 32'd1, e, nr, nw, cy);
    chk("ro_err", 64'(e), 64'd1);
    chk("ro_nwr", 64'(nw), 64'd0);
    chk("ro_nrd", 64'(nr), 64'd0);
    run_op(1'b0, 1'b1, 7'd0, 4'd3, 32'd1, e, nr, nw, cy);
    chk("both_err", 64'(e), 64'd0);
    chk("both_nwr", 64'(nw), 64'd0);
    chk_sector("both_data", 1, 1'b1);

    // Mount during a transfer ends that operation with an error.
    mount(64'd102400, 1'b0);
    g_mount_mid = 1'b1;
    run_op(1'b0, 1'b0, 7'd0, 4'd4, 32'd2, e, nr, nw, cy);
    g_mount_mid = 1'b0;
    chk("abort_err", 64'(e), 64'd1);
    chk("abort_nrd", 64'(nr), 64'd1);
    run_op(1'b0, 1'b0, 7'd0, 4'd4, 32'd2, e, nr, nw, cy);
    chk("after_abort_err", 64'(e), 64'd0);
    chk("after_abort_nrd", 64'(nr), 64'd1);
    chk_sector("after_abort_data", 2, 1'b0);

    // Reset in the middle of a read transfer.
    bus.track = 7'd0; bus.sector = 4'd2; bus.req_rd = 1'b1;
    tick;
    bus.req_rd = 1'b0;
    for (int k = 0; k < 20 && !bus.sd_rd; k++) tick;
    chk("mid_rst_sd_rd", 64'(bus.sd_rd), 64'd1);
    bus.sd_ack = 1'b1;
    tick;
    for (int i = 0; i < 50; i++) begin
      bus.sd_buff_addr = 9'(i);
      bus.sd_buff_dout = 8'hEE;
      bus.sd_buff_wr   = 1'b1;
      tick;
    end
    bus.sd_buff_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rd", 64'(bus.sd_rd), 64'd0);
    chk("mid_rst_wr", 64'(bus.sd_wr), 64'd0);
    chk("mid_rst_lba", 64'(bus.sd_lba), 64'd0);
    chk("mid_rst_dout", 64'(bus.buf_dout), 64'd0);
    chk("mid_rst_din", 64'(bus.sd_buff_din), 64'd0);
    tick; tick;
    rst_n = 1'b1;
    tick; tick;
    chk("late_ack_busy", 64'(bus.busy), 64'd0);
    chk("late_ack_done", 64'(bus.done), 64'd0);
    bus.sd_ack = 1'b0;
    tick;
    run_op(1'b0, 1'b0, 7'd0, 4'd2, 32'd1, e, nr, nw, cy);
    chk("post_rst_nosize_err", 64'(e), 64'd1);
    chk("post_rst_nosize_nrd", 64'(nr), 64'd0);
    mount(64'd102400, 1'b0);
    run_op(1'b0, 1'b0, 7'd0, 4'd2, 32'd1, e, nr, nw, cy);
    chk("post_rst_err", 64'(e), 64'd0);
    chk("post_rst_nrd", 64'(nr), 64'd1);
    chk_sector("post_rst_data", 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jv1_sector_bridge.md
Name: jv1_sector_bridge

Overview:
- Sits between the hps_io SD block interface and the TRS-80 floppy controller.
- Maps JV1 track/sector requests onto 512-byte SD blocks: 10 sectors per track, 256 bytes per sector, single sided.
- Holds one 512-byte block buffer and one 256-byte write staging buffer.
- Serves FDC byte reads and writes through a local RAM port; writes use read-modify-write of the containing block.

Parameters:
- TRACKS, 40, number of tracks accepted; requests at or above this value are errors.
- SPT, 10, sectors per track (JV1 fixed).

Ports:
- clk_sys  in  1  system clock (42 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- req_rd  in  1  one-cycle pulse: read sector.
- req_wr  in  1  one-cycle pulse: write staged sector.
- track  in  7  track number, sampled on req.
- sector  in  4  sector number, sampled on req.
- buf_addr  in  8  FDC byte address within the sector.
- buf_dout  out  8  sector byte; valid 1 cycle after buf_addr.
- buf_din  in  8  byte for the staging buffer.
- buf_we  in  1  write buf_din to stage[buf_addr].
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse at the end of every accepted request.
- err  out  1  valid with done; held until the next request.
- sd_lba  out  32  SD block address.
- sd_rd  out  1  SD read request.
- sd_wr  out  1  SD write request.
- sd_ack  in  1  high for the duration of an SD transfer.
- sd_buff_addr  in  9  SD transfer byte index.
- sd_buff_dout  in  8  SD read data.
- sd_buff_din  out  8  SD write data; registered, valid 1 cycle after sd_buff_addr.
- sd_buff_wr  in  1  SD read data strobe.
- img_mounted  in  1  mount pulse.
- img_readonly  in  1  sampled on img_mounted.
- img_size  in  64  image bytes, sampled on img_mounted.

Behaviour:
- Reset values: all outputs 0; cache invalid; latched size 0; state IDLE.
- Index arithmetic, 10-bit unsigned: idx = track*SPT + sector; lba = idx>>1 zero-extended to 32 bits; half = idx[0].
- Validity check:
  - sector < SPT
  - track < TRACKS
  - latched size != 0
  - (idx+1)*256 <= latched size
  - for writes only: not readonly.
- States:
  - IDLE: on req_rd, latch the address and go to CHECK; busy rises the next cycle. req_rd wins over req_wr when both pulse together. Requests are ignored while busy.
  - CHECK: invalid -> DONE with err=1. Read hit (cache valid, cached_lba==lba) -> DONE. Otherwise -> RD_REQ. Write hit -> WR_REQ. Write miss -> RD_REQ, then WR_REQ.
  - RD_REQ: drive sd_lba and sd_rd=1 until sd_ack rises, then clear sd_rd and go to RD_XFER.
  - RD_XFER: on each sd_buff_wr, block[sd_buff_addr] <= sd_buff_dout. When sd_ack falls: cache valid, cached_lba=lba, then go to DONE (read) or WR_REQ (write).
  - WR_REQ: sd_wr=1 until sd_ack rises, then go to WR_XFER.
  - WR_XFER: sd_buff_din = stage[addr[7:0]] if addr[8]==half, else block[addr]. Each target-half byte is also copied into block. When sd_ack falls -> DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- buf_dout reads block[{half,buf_addr}] in every state. Its contents are only defined after a read done without err.
- Stage buffer is written by buf_we at any time. Data written while busy in WR_XFER is undefined.
- img_mounted: latch size and readonly, and invalidate the cache. If busy at the time, the current operation completes its SD handshake and ends with err=1.
- reset_n low mid-transfer: immediate return to IDLE with sd_rd/sd_wr=0 and cache invalid. Late sd_ack is ignored until the next request.

Optional Feature:
- Macro: JV1_SECTOR_CACHE_EN.
- Defined: hit detection as above; read hits take no SD access; write hits skip the pre-read.
- Undefined: every read issues RD_REQ; every write pre-reads its block. cached_lba logic is removed.

Test Plan:
- Mount size 102400. req_rd t0 s0 -> sd_lba=0, sd_rd held until ack. Feed bytes 0..511 = addr[7:0]. Required: done with err=0; buf_dout[0..255] = 0..255.
- Then req_rd t0 s1 -> with the cache macro, no sd_rd and done ≤3 cycles after req. buf_dout[5]=5, taken from block byte 261.
- req_rd t1 s3 -> idx 13: sd_lba=6, half=1. With size 3328 (13*256), err=1 with no sd_rd.
- req_rd sector=10, or track=TRACKS -> done+err within 3 cycles; sd_rd never asserted.
- Stage 0xA5×256, req_wr t0 s2 with a cache miss -> RD lba 1, then WR lba 1. sd_buff_din = 0xA5 for addr 0..255, original data for 256..511. With readonly mounted -> err, no sd_wr.
- Pull reset_n low during RD_XFER -> outputs 0. The next req_rd on the same lba re-issues sd_rd (cache invalid).
